// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Register map, ap_ctrl bit positions and read FSM encodings.
// Revision    : 1.0
// ============================================================================
package fir_pkg;

    localparam int unsigned ADDR_AP_CTRL  = 32'h00;
    localparam int unsigned ADDR_DATA_LEN = 32'h10;
    localparam int unsigned ADDR_TAP_BASE = 32'h20;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_VALID = 2'd2
    } rd_state_t;

    // Taps are word-addressed; unaligned offsets inside the window are unmapped.
    function automatic logic is_tap_addr(input int unsigned addr, input int unsigned tap_num);
        return (addr >= ADDR_TAP_BASE) &&
               (addr <= ADDR_TAP_BASE + 32'd4 * (tap_num - 32'd1)) &&
               (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_axil_rd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fir_axil_rd_fsm
// Description : AXI-Lite read channel: AR accept, one-cycle BRAM wait, held R.
// Revision    : 1.0
// ============================================================================
module fir_axil_rd_fsm
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ar_block,
    output logic [pADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_issue,
    output logic                   rd_accept,
    input  logic                   rd_from_tap,
    input  logic [pDATA_WIDTH-1:0] rd_reg_data,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;
    logic                   r_use_tap;
    logic [pDATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rd_issue    = 1'b0;
        rd_accept   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !ar_block;
                if (arvalid && !ar_block) begin
                    w_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                rd_issue    = 1'b1;
                w_state_nxt = R_VALID;
            end
            R_VALID: begin
                rvalid = 1'b1;
                if (rready) begin
                    rd_accept   = 1'b1;
                    w_state_nxt = R_IDLE;
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    // BRAM output is only trusted in the first R_VALID cycle; it is captured
    // there so a later write commit cannot disturb data still awaiting rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            r_use_tap <= 1'b0;
            r_data    <= '0;
        end else begin
            if (arvalid && arready) begin
                rd_addr <= araddr;
            end
            if (rd_issue) begin
                r_use_tap <= rd_from_tap;
                r_data    <= rd_reg_data;
            end else if (rvalid && r_use_tap) begin
                r_use_tap <= 1'b0;
                r_data    <= tap_Do;
            end
        end
    end

    assign rdata = rvalid ? (r_use_tap ? tap_Do : r_data) : '0;

endmodule
`default_nettype wire

// File: rtl/fir_axil_responder.sv
`default_nettype none
// ============================================================================
// Module      : fir_axil_responder
// Description : AXI-Lite slave for FIR control, data length and tap BRAM.
// Revision    : 1.0
// ============================================================================
module fir_axil_responder
    import fir_pkg::*;
#(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start_o,
    input  logic                   engine_done_i,
    input  logic [pADDR_WIDTH-1:0] engine_tap_A,
    output logic [31:0]            data_length_o
);

    logic                   r_aw_full;
    logic                   r_w_full;
    logic [pADDR_WIDTH-1:0] r_aw_addr;
    logic [pDATA_WIDTH-1:0] r_w_data;
    logic                   r_ap_done;
    logic                   r_ap_idle;
    logic [31:0]            r_data_length;

    logic                   w_commit;
    logic                   w_aw_sel_ctrl;
    logic                   w_aw_sel_len;
    logic                   w_aw_sel_tap;
    logic                   w_tap_wr;
    logic                   w_len_wr;
    logic                   w_ar_block;
    logic [pADDR_WIDTH-1:0] w_rd_addr;
    logic                   w_rd_issue;
    logic                   w_rd_accept;
    logic                   w_rd_sel_tap;
    logic                   w_rd_from_tap;
    logic                   w_done_clear;
    logic [pDATA_WIDTH-1:0] w_rd_reg_data;

    assign awready       = !r_aw_full;
    assign wready        = !r_w_full;
    assign w_commit      = r_aw_full && r_w_full;
    assign w_aw_sel_ctrl = (r_aw_addr == pADDR_WIDTH'(ADDR_AP_CTRL));
    assign w_aw_sel_len  = (r_aw_addr == pADDR_WIDTH'(ADDR_DATA_LEN));
    assign w_aw_sel_tap  = is_tap_addr(32'(r_aw_addr), Tape_Num);
    assign w_tap_wr      = w_commit && w_aw_sel_tap && r_ap_idle;
    assign w_len_wr      = w_commit && w_aw_sel_len && r_ap_idle;
    assign ap_start_o    = w_commit && w_aw_sel_ctrl && r_w_data[AP_START_BIT] && r_ap_idle;
    assign data_length_o = r_data_length;

    // Hold AR off whenever both write halves are present (or will be next
    // cycle), so a same-cycle read observes the committed write.
    assign w_ar_block = (r_aw_full || awvalid) && (r_w_full || wvalid);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                r_w_full <= 1'b1;
                r_w_data <= wdata;
            end
        end
    end

    assign w_done_clear = w_rd_accept && (w_rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_ap_done     <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_data_length <= '0;
        end else begin
            if (engine_done_i) begin
                r_ap_done <= 1'b1;
                r_ap_idle <= 1'b1;
            end else if (ap_start_o) begin
                r_ap_done <= 1'b0;
                r_ap_idle <= 1'b0;
            end else if (w_done_clear) begin
                r_ap_done <= 1'b0;
            end
            if (w_len_wr) begin
                r_data_length <= 32'(r_w_data);
            end
        end
    end

    assign w_rd_sel_tap  = is_tap_addr(32'(w_rd_addr), Tape_Num);
    assign w_rd_from_tap = w_rd_sel_tap && r_ap_idle;

    always_comb begin
        w_rd_reg_data = '0;
        if (w_rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
            w_rd_reg_data[AP_DONE_BIT] = r_ap_done;
            w_rd_reg_data[AP_IDLE_BIT] = r_ap_idle;
        end else if (w_rd_addr == pADDR_WIDTH'(ADDR_DATA_LEN)) begin
            w_rd_reg_data = pDATA_WIDTH'(r_data_length);
        end else if (w_rd_sel_tap) begin
            w_rd_reg_data = '1;
        end
    end

    // The engine owns the tap BRAM port for the whole busy period.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (!r_ap_idle) begin
            tap_EN = 1'b1;
            tap_A  = engine_tap_A;
        end else if (w_tap_wr) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = r_aw_addr - pADDR_WIDTH'(ADDR_TAP_BASE);
            tap_Di = r_w_data;
        end else if (w_rd_issue && w_rd_from_tap) begin
            tap_EN = 1'b1;
            tap_A  = w_rd_addr - pADDR_WIDTH'(ADDR_TAP_BASE);
        end
    end

    fir_axil_rd_fsm #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_rd_fsm (
        .clk         (axis_clk),
        .rst_n       (axis_rst_n),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .ar_block    (w_ar_block),
        .rd_addr     (w_rd_addr),
        .rd_issue    (w_rd_issue),
        .rd_accept   (w_rd_accept),
        .rd_from_tap (w_rd_from_tap),
        .rd_reg_data (w_rd_reg_data),
        .tap_Do      (tap_Do)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_axil_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_axil_responder
// Description : Scoreboard bench for fir_axil_responder with a tap BRAM model.
// Revision    : 1.0
// ============================================================================
module tb_fir_axil_responder;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, arready, rvalid;
    logic [AW-1:0] awaddr = '0, araddr = '0, tap_A;
    logic [AW-1:0] engine_tap_A = 12'h00C;
    logic [DW-1:0] wdata = '0, rdata, tap_Di;
    logic [DW-1:0] tap_Do = '0;
    logic [3:0]    tap_WE;
    logic          tap_EN, ap_start_o;
    logic          engine_done_i = 1'b0;
    logic [31:0]   data_length_o;

    fir_axil_responder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .ap_start_o(ap_start_o), .engine_done_i(engine_done_i),
        .engine_tap_A(engine_tap_A), .data_length_o(data_length_o)
    );

    always #5 axis_clk = ~axis_clk;

    // Synchronous read-first tap BRAM
    logic [31:0] bram [1024];
    initial for (int i = 0; i < 1024; i++) bram[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) bram[tap_A[11:2]] <= tap_Di;
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
    wr_t         wr_q [$];
    logic [31:0] rd_exp_q [$];
    int          ar_cyc_q [$];

    logic [31:0] tap_model [11];
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    logic [31:0] m_len = '0;

    int   start_pulses = 0;
    int   last_wr_cyc = -1;
    int   w_hs_cyc = -1;
    logic prev_rvalid = 1'b0;

    always @(negedge axis_clk) begin
        if (axis_rst_n) begin
            if (ap_start_o) start_pulses++;
            if (arvalid && arready) ar_cyc_q.push_back(cyc);
            if (rvalid && !prev_rvalid) begin
                if (ar_cyc_q.size() > 0) check_eq("rd_latency", 32'(cyc - ar_cyc_q.pop_front()), 32'd2);
                else check_eq("rd_unexp", 32'(rvalid), 32'd0);
            end
            if (rvalid) begin
                if (rd_exp_q.size() > 0) begin
                    check_eq("rdata", rdata, rd_exp_q[0]);
                    if (rready) void'(rd_exp_q.pop_front());
                end else check_eq("rd_unexp", 32'(rvalid), 32'd0);
            end
            if (tap_EN && tap_WE != 4'h0) begin
                wr_t e;
                last_wr_cyc = cyc;
                check_eq("ar_blk_commit", 32'(arready), 32'd0);
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    check_eq("tap_A", 32'(tap_A), 32'(e.a));
                    check_eq("tap_Di", tap_Di, e.d);
                    check_eq("tap_WE", 32'(tap_WE), 32'hF);
                end else check_eq("tap_wr_unexp", 32'(tap_WE), 32'd0);
            end
        end
        prev_rvalid = rvalid;
    end

    function automatic bit tb_is_tap(input logic [11:0] a);
        return (a >= 12'h20) && (a <= 12'h48) && (a[1:0] == 2'b00);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        if (tb_is_tap(a) && m_idle) begin
            wr_q.push_back('{a: a - 12'h20, d: d});
            tap_model[(a - 12'h20) >> 2] = d;
        end else if (a == 12'h00 && d[0] && m_idle) begin
            m_idle = 1'b0;
            m_done = 1'b0;
        end else if (a == 12'h10 && m_idle) begin
            m_len = d;
        end
    endtask

    task automatic push_read_exp(input logic [11:0] a);
        logic [31:0] e;
        e = '0;
        if (a == 12'h00) begin
            e = {29'd0, m_idle, m_done, 1'b0};
            m_done = 1'b0;
        end else if (a == 12'h10) e = m_len;
        else if (tb_is_tap(a)) e = m_idle ? tap_model[(a - 12'h20) >> 2] : 32'hFFFF_FFFF;
        rd_exp_q.push_back(e);
    endtask

    task automatic send_aw(input logic [11:0] a, input int dly);
        bit ok = 0;
        if (dly > 0) tick(dly);
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) check_eq("aw_timeout", 32'(awready), 32'd1);
        tick(1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input int dly);
        bit ok = 0;
        if (dly > 0) tick(dly);
        wdata = d; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (wready) begin ok = 1; w_hs_cyc = cyc; break; end
        end
        if (!ok) check_eq("w_timeout", 32'(wready), 32'd1);
        tick(1);
        wvalid = 1'b0;
    endtask

    task automatic do_ar_r(input logic [11:0] a, input int rdly);
        bit ok = 0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) check_eq("ar_timeout", 32'(arready), 32'd1);
        tick(1);
        arvalid = 1'b0;
        if (rdly > 0) tick(rdly);
        rready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (rvalid) begin ok = 1; break; end
        end
        if (!ok) check_eq("r_timeout", 32'(rvalid), 32'd1);
        tick(1);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input int aw_dly, input int w_dly);
        model_write(a, d);
        fork
            send_aw(a, aw_dly);
            send_w(d, w_dly);
        join
        tick(2);
    endtask

    task automatic axi_read(input logic [11:0] a, input int rdly);
        push_read_exp(a);
        do_ar_r(a, rdly);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 11; i++) tap_model[i] = '0;
        #12;
        check_eq("rst_awready", 32'(awready), 32'd1);
        check_eq("rst_wready", 32'(wready), 32'd1);
        check_eq("rst_arready", 32'(arready), 32'd1);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_tap_EN", 32'(tap_EN), 32'd0);
        check_eq("rst_tap_WE", 32'(tap_WE), 32'd0);
        check_eq("rst_start", 32'(ap_start_o), 32'd0);
        check_eq("rst_len", data_length_o, 32'd0);
        tick(2);
        axis_rst_n = 1'b1;
        tick(1);

        // AW first, W three cycles later
        axi_write(12'h020, 32'h5, 0, 3);
        check_eq("wr_latency", 32'(last_wr_cyc - w_hs_cyc), 32'd1);
        axi_read(12'h020, 0);

        for (int i = 0; i < 11; i++) axi_write(12'(12'h20 + 4 * i), 32'(i), i % 3, (i + 1) % 2);
        axi_write(12'h010, 32'h40, 0, 0);
        axi_write(12'h100, 32'hDEAD, 0, 0);
        axi_write(12'h04C, 32'hBEEF, 1, 0);
        for (int i = 0; i < 11; i++) axi_read(12'(12'h20 + 4 * i), (i == 7) ? 5 : 0);
        axi_read(12'h010, 0);
        axi_read(12'h014, 0);
        axi_read(12'h04C, 2);
        axi_read(12'h000, 0);

        // Start, busy behaviour
        check_eq("start_cnt0", 32'(start_pulses), 32'd0);
        axi_write(12'h000, 32'h1, 0, 0);
        check_eq("start_cnt1", 32'(start_pulses), 32'd1);
        axi_read(12'h000, 0);
        axi_read(12'h02C, 0);
        @(negedge axis_clk);
        check_eq("eng_tap_A", 32'(tap_A), 32'(engine_tap_A));
        check_eq("eng_tap_EN", 32'(tap_EN), 32'd1);
        check_eq("eng_tap_WE", 32'(tap_WE), 32'd0);
        tick(1);
        axi_write(12'h02C, 32'h99, 0, 0);
        axi_write(12'h010, 32'h77, 0, 0);
        axi_read(12'h010, 0);
        axi_write(12'h000, 32'h1, 0, 0);
        check_eq("start_cnt2", 32'(start_pulses), 32'd1);

        engine_done_i = 1'b1;
        m_done = 1'b1; m_idle = 1'b1;
        tick(1);
        engine_done_i = 1'b0;
        tick(1);
        axi_read(12'h000, 0);
        axi_read(12'h000, 0);
        axi_read(12'h02C, 0);

        // AW, W and AR presented together
        model_write(12'h024, 32'h77);
        push_read_exp(12'h024);
        fork
            send_aw(12'h024, 0);
            send_w(32'h77, 0);
            do_ar_r(12'h024, 0);
        join
        tick(2);

        // Reset between AW and W acceptance
        send_aw(12'h02C, 0);
        axis_rst_n = 1'b0;
        m_idle = 1'b1; m_done = 1'b0; m_len = '0;
        tick(2);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_eq("post_rst_awready", 32'(awready), 32'd1);
        check_eq("post_rst_len", data_length_o, 32'd0);
        tick(1);
        send_w(32'hAB, 0);
        tick(3);
        check_eq("w_pending", 32'(wready), 32'd0);
        model_write(12'h028, 32'hAB);
        send_aw(12'h028, 0);
        tick(2);
        axi_read(12'h02C, 0);
        axi_read(12'h028, 0);
        axi_read(12'h000, 0);
        axi_read(12'h010, 0);

        tick(4);
        check_eq("rd_q_empty", 32'(rd_exp_q.size()), 32'd0);
        check_eq("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
